mux4_input_16bit: RTL and testbench
===================================

Name: mux4_input_16bit

Overview:
- Four-way, WIDTH-bit (default 16) datapath selector used in the processor datapath, e.g. for ALU operand, PC-source and write-back selection.
- Combinational output O is selected from A/B/C/D by the 2-bit select S.
- A registered copy of the selection (Q) is provided for pipelined consumers.
- One clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 16, bit width of each data input and of both outputs.
- RESET_VAL, 0 (WIDTH bits), value loaded into Q during reset.

Ports:
- CLK  input  1  rising-edge clock; used only by Q.
- RST_N  input  1  asynchronous active-low reset; affects only Q.
- A  input  WIDTH  data input, selected when S=2'b00.
- B  input  WIDTH  data input, selected when S=2'b01.
- C  input  WIDTH  data input, selected when S=2'b10.
- D  input  WIDTH  data input, selected when S=2'b11.
- S  input  2  select code.
- O  output  WIDTH  combinational selected value.
- Q  output  WIDTH  registered selected value.

Behaviour:
- O is purely combinational, with zero cycles of latency:
  - S=0 -> O=A
  - S=1 -> O=B
  - S=2 -> O=C
  - S=3 -> O=D
- O settles within the same time step as any input change. It does not depend on CLK or RST_N, so it is valid during reset.
- All four select codes are legal; there is no default/undefined output.
- If S contains X or Z in simulation, O is all-X; it must not silently fall through to any input.
- O passes bits through unchanged: no sign extension, no arithmetic.
- Q timing:
  - On each CLK rising edge with RST_N=1, Q <= the value O has before the edge, i.e. one cycle of latency relative to the inputs.
  - RST_N=0 forces Q=RESET_VAL immediately, independent of CLK.
  - While RST_N is held low, Q stays at RESET_VAL.
- Reset deassertion:
  - Deassert RST_N synchronously relative to CLK at the system level.
  - The first capture occurs on the first rising edge after RST_N is high.
- Reset asserted mid-operation: Q clears asynchronously and O continues to track its inputs.
- Simultaneous input and select change before an edge: Q captures the combination present at the edge.
- There is no enable and no handshake; Q loads every cycle.

Decomposition:
- Shared package (datapath_pkg): WIDTH default constant (16).
- Shared package: select-code constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11, so that the control unit and the datapath use the same encodings.
- One sub-module is natural: a generic 2:1 WIDTH-bit mux (mux2_w).
  - Instantiate it three times as a tree: S[0] chooses A/B and C/D; S[1] chooses between the two results.
- The output register is inline in the top module.

Test Plan:
- Exhaustive select sweep, no clock needed: A=16'h1111, B=16'h2222, C=16'h3333, D=16'h4444. S=0,1,2,3 -> O=1111, 2222, 3333, 4444 respectively. The S=3 case must be checked against D, not against zero.
- Input sweep:
  - Nested loops over A, B, C and D, each counting 0..63, with all four S values per combination.
  - O must equal the selected input at every step. Unselected inputs changing must not disturb O; e.g. S=1, B=5, toggle A/C/D -> O stays 5.
- Full-width extremes: A=16'hFFFF, B=16'h0000, C=16'hAAAA, D=16'h5555, all S values -> exact pass-through, with no bit corruption at bits 15 or 0.
- Registered path:
  - Setup: RST_N=0 -> Q=0 with no clock. Release RST_N, S=2, C=16'hBEEF.
  - After the first rising edge, Q=BEEF. Change S to 3 with D=16'h1234: O=1234 immediately; Q=1234 only after the next edge.
- Mid-operation reset: with Q=16'h1234, pull RST_N low between edges -> Q=0 at once while O still shows 1234. Keep RST_N low across edges -> Q stays 0.
- X-select: drive S=2'bx0 -> O is all-X (simulation check only).

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants: default data width and the 4:1 select-code
// encodings used by both the control unit and the datapath selectors.
package datapath_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned SEL_WIDTH  = 2;

  typedef logic [SEL_WIDTH-1:0]  sel_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux2_w.sv
// Generic WIDTH-bit 2:1 selector.
//   sel  : 0 -> in0, 1 -> in1
//   in0  : data input selected when sel=0
//   in1  : data input selected when sel=1
//   y_c  : combinational selected value
module mux2_w
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y_c
);

  // An unknown select drives all-X instead of falling through to an input.
  always_comb begin
    y_c = {WIDTH{1'bx}};
    case (sel)
      1'b0:    y_c = in0;
      1'b1:    y_c = in1;
      default: y_c = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/mux4_input_16bit.sv
// Four-way WIDTH-bit datapath selector with a registered copy of the result.
//   CLK   : rising-edge clock, used only by Q
//   RST_N : asynchronous active-low reset, affects only Q
//   A..D  : data inputs selected by S = 00/01/10/11
//   S     : select code (SEL_A..SEL_D)
//   O     : combinational selected value, valid during reset
//   Q     : O registered, one cycle of latency, RESET_VAL under reset
module mux4_input_16bit
  import datapath_pkg::*;
#(
  parameter int unsigned     WIDTH     = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] ab_c;
  logic [WIDTH-1:0] cd_c;
  logic [WIDTH-1:0] o_c;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // First level: S[0] picks within each pair.
  mux2_w #(.WIDTH(WIDTH)) u_mux_ab (
    .sel (S[0]),
    .in0 (A),
    .in1 (B),
    .y_c (ab_c)
  );

  mux2_w #(.WIDTH(WIDTH)) u_mux_cd (
    .sel (S[0]),
    .in0 (C),
    .in1 (D),
    .y_c (cd_c)
  );

  // Second level: S[1] picks between the pair results.
  mux2_w #(.WIDTH(WIDTH)) u_mux_out (
    .sel (S[1]),
    .in0 (ab_c),
    .in1 (cd_c),
    .y_c (o_c)
  );

  assign O = o_c;

  // Q loads every cycle; no enable.
  always_comb begin
    q_d = o_c;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_mux4_input_16bit.sv
// Directed self-checking bench for mux4_input_16bit.
module tb_mux4_input_16bit;
  import datapath_pkg::*;

  localparam int unsigned W = 16;

  logic         CLK;
  logic         RST_N;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic [W-1:0] D;
  logic [1:0]   S;
  logic [W-1:0] O;
  logic [W-1:0] Q;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_input_16bit #(.WIDTH(W), .RESET_VAL('0)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .S     (S),
    .O     (O),
    .Q     (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_sel(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c,
                                           input logic [W-1:0] d,
                                           input logic [1:0]   s);
    case (s)
      SEL_A:   return a;
      SEL_B:   return b;
      SEL_C:   return c;
      SEL_D:   return d;
      default: return {W{1'bx}};
    endcase
  endfunction

  initial begin
    logic [W-1:0] exp_v [4];

    RST_N = 1'b1;
    A = '0; B = '0; C = '0; D = '0; S = SEL_A;
    #1 RST_N = 1'b0;
    #1 check("reset_q_no_clock", Q, 16'h0000);

    // Exhaustive select sweep with distinct patterns.
    A = 16'h1111; B = 16'h2222; C = 16'h3333; D = 16'h4444;
    exp_v[0] = 16'h1111; exp_v[1] = 16'h2222;
    exp_v[2] = 16'h3333; exp_v[3] = 16'h4444;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1 check($sformatf("sel_sweep_s%0d", s), O, exp_v[s]);
    end

    // Full-width extremes: bits 15 and 0 must pass through intact.
    A = 16'hFFFF; B = 16'h0000; C = 16'hAAAA; D = 16'h5555;
    exp_v[0] = 16'hFFFF; exp_v[1] = 16'h0000;
    exp_v[2] = 16'hAAAA; exp_v[3] = 16'h5555;
    for (int s = 0; s < 4; s++) begin
      S = 2'(s);
      #1 check($sformatf("extreme_s%0d", s), O, exp_v[s]);
    end

    // Input grid: each input over 0..63 (stride 9), all selects per point.
    for (int a = 0; a < 64; a += 9) begin
      for (int b = 0; b < 64; b += 9) begin
        for (int c = 0; c < 64; c += 9) begin
          for (int d = 0; d < 64; d += 9) begin
            A = W'(a); B = W'(b); C = W'(c); D = W'(d);
            for (int s = 0; s < 4; s++) begin
              S = 2'(s);
              #1 check("grid", O, ref_sel(A, B, C, D, S));
            end
          end
        end
      end
    end

    // Unselected inputs toggling must not disturb O.
    S = SEL_B; B = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      A = W'(i * 7 + 1); C = W'(16'hF0F0 ^ (i * 3)); D = W'(16'h8001 + i);
      #1 check("unselected_toggle", O, 16'h0005);
    end

    // Reset was held across many edges during the sweeps.
    check("reset_held_q", Q, 16'h0000);

    // Registered path: release reset between edges.
    @(negedge CLK);
    S = SEL_C; C = 16'hBEEF; RST_N = 1'b1;
    #1 check("q_before_first_edge", Q, 16'h0000);
    @(posedge CLK); #1;
    check("q_first_capture", Q, 16'hBEEF);

    @(negedge CLK);
    S = SEL_D; D = 16'h1234;
    #1 check("o_immediate_d", O, 16'h1234);
    check("q_holds_old", Q, 16'hBEEF);
    @(posedge CLK); #1;
    check("q_after_edge_d", Q, 16'h1234);

    // Simultaneous input and select change before an edge.
    @(negedge CLK);
    S = SEL_A; A = 16'h0F0F;
    @(posedge CLK); #1;
    check("q_simul_change", Q, 16'h0F0F);

    @(negedge CLK);
    S = SEL_D; D = 16'h1234;
    @(posedge CLK); #1;
    check("q_restore", Q, 16'h1234);

    // Mid-operation reset between edges.
    #2 RST_N = 1'b0;
    #1 check("q_async_clear", Q, 16'h0000);
    check("o_during_reset", O, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("q_reset_held_edge", Q, 16'h0000);
    end

    // Release again; first edge afterwards captures.
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("q_recapture", Q, 16'h1234);

    // Unknown select bit must give all-X, never an input.
    A = 16'h0A0A; B = 16'h0B0B; C = 16'h0C0C; D = 16'h0D0D;
    S = 2'bx0;
    #1;
    if ($isunknown(S)) begin
      check("x_select", O, {W{1'bx}});
    end else begin
      check("x_select_2state", O, ref_sel(A, B, C, D, S));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
